// File: rtl/pipelined_barrel_shifter_if.sv
// rtl/pipelined_barrel_shifter_if.sv - stream interface for the pipelined barrel shifter (optional flags: BSH_FLAGS_EN)
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int AMT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] a_in;
    logic [AMT_W-1:0] amt_in;
    logic [2:0]       mode_in;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] out_out;
    logic             valid_out;
    logic             ready_in;
`ifdef BSH_FLAGS_EN
    logic             zero_out;
    logic             carry_out;

    modport master (
        output a_in, amt_in, mode_in, valid_in, ready_in,
        input  ready_out, out_out, valid_out, zero_out, carry_out
    );

    modport slave (
        input  a_in, amt_in, mode_in, valid_in, ready_in,
        output ready_out, out_out, valid_out, zero_out, carry_out
    );
`else
    modport master (
        output a_in, amt_in, mode_in, valid_in, ready_in,
        input  ready_out, out_out, valid_out
    );

    modport slave (
        input  a_in, amt_in, mode_in, valid_in, ready_in,
        output ready_out, out_out, valid_out
    );
`endif
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined rotate/shift unit, one stage per amount bit (optional flags: BSH_FLAGS_EN)
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int AMT_W = $clog2(WIDTH);

    localparam logic [2:0] MODE_ROL = 3'b000;
    localparam logic [2:0] MODE_ROR = 3'b001;
    localparam logic [2:0] MODE_SLL = 3'b010;
    localparam logic [2:0] MODE_SRL = 3'b011;
    localparam logic [2:0] MODE_SRA = 3'b100;

    // Stage registers; mode, fill and remaining amount are not needed past the last stage
    logic [AMT_W-1:0][WIDTH-1:0] r_data;
    logic [AMT_W-1:0]            r_valid;
    logic [AMT_W-2:0][AMT_W-1:0] r_amt;
    logic [AMT_W-2:0][2:0]       r_mode;
    logic [AMT_W-2:0]            r_fill;

    // Inputs seen by each stage and the value each stage will load
    logic [AMT_W-1:0][WIDTH-1:0] w_in_data;
    logic [AMT_W-1:0][AMT_W-1:0] w_in_amt;
    logic [AMT_W-1:0][2:0]       w_in_mode;
    logic [AMT_W-1:0]            w_in_fill;
    logic [AMT_W-1:0]            w_in_valid;
    logic [AMT_W-1:0][WIDTH-1:0] w_nxt_data;
    logic                        w_stall;

    // One fixed-distance step; sh is a per-stage constant so this folds to wiring and muxes
    function automatic logic [WIDTH-1:0] f_stage(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       mode,
        input logic             fill,
        input int               sh
    );
        logic [WIDTH-1:0] w_fill_mask;
        logic [WIDTH-1:0] w_res;
        w_fill_mask = ~({WIDTH{1'b1}} >> sh);
        case (mode)
            MODE_ROL: w_res = (d << sh) | (d >> (WIDTH - sh));
            MODE_ROR: w_res = (d >> sh) | (d << (WIDTH - sh));
            MODE_SLL: w_res = d << sh;
            MODE_SRL: w_res = d >> sh;
            MODE_SRA: w_res = (d >> sh) | (fill ? w_fill_mask : '0);
            default:  w_res = d;
        endcase
        return w_res;
    endfunction

    // The whole pipe freezes only when the output holds a result nobody takes
    assign w_stall       = r_valid[AMT_W-1] & ~bus.ready_in;
    assign bus.ready_out = ~w_stall;
    assign bus.out_out   = r_data[AMT_W-1];
    assign bus.valid_out = r_valid[AMT_W-1];

    // Route the entry port into stage 0 and each stage register into the next stage
    always_comb begin
        w_in_data  = '0;
        w_in_amt   = '0;
        w_in_mode  = '0;
        w_in_fill  = '0;
        w_in_valid = '0;
        w_in_data[0]  = bus.a_in;
        w_in_amt[0]   = bus.amt_in;
        w_in_mode[0]  = bus.mode_in;
        w_in_fill[0]  = bus.a_in[WIDTH-1];
        w_in_valid[0] = bus.valid_in;
        for (int k = 1; k < AMT_W; k++) begin
            w_in_data[k]  = r_data[k-1];
            w_in_amt[k]   = r_amt[k-1];
            w_in_mode[k]  = r_mode[k-1];
            w_in_fill[k]  = r_fill[k-1];
            w_in_valid[k] = r_valid[k-1];
        end
    end

    // Stage k shifts by 2^k when bit 0 of its remaining amount is set
    always_comb begin
        w_nxt_data = '0;
        for (int k = 0; k < AMT_W - 1; k++) begin
            w_nxt_data[k] = w_in_amt[k][0]
                          ? f_stage(w_in_data[k], w_in_mode[k], w_in_fill[k], 1 << k)
                          : w_in_data[k];
        end
        // Only bit 0 can still be set when the amount reaches the last stage
        w_nxt_data[AMT_W-1] = (w_in_amt[AMT_W-1] != '0)
                            ? f_stage(w_in_data[AMT_W-1], w_in_mode[AMT_W-1],
                                      w_in_fill[AMT_W-1], 1 << (AMT_W - 1))
                            : w_in_data[AMT_W-1];
    end

    // Advance every stage together; reset discards anything in flight
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_data  <= '0;
            r_valid <= '0;
            r_amt   <= '0;
            r_mode  <= '0;
            r_fill  <= '0;
        end else if (!w_stall) begin
            r_data  <= w_nxt_data;
            r_valid <= w_in_valid;
            for (int k = 0; k < AMT_W - 1; k++) begin
                r_amt[k]  <= w_in_amt[k] >> 1;
                r_mode[k] <= w_in_mode[k];
                r_fill[k] <= w_in_fill[k];
            end
        end
    end

`ifdef BSH_FLAGS_EN
    logic [AMT_W-1:0] r_carry;
    logic             r_zero;
    logic [AMT_W-1:0] w_left_idx;
    logic [AMT_W-1:0] w_right_idx;
    logic             w_entry_carry;

    assign bus.zero_out  = r_zero;
    assign bus.carry_out = r_carry[AMT_W-1];

    // Last bit pushed out, taken from the operand at entry; WIDTH-amt wraps to -amt in AMT_W bits
    always_comb begin
        w_left_idx    = '0 - bus.amt_in;
        w_right_idx   = bus.amt_in - 1'b1;
        w_entry_carry = 1'b0;
        if (bus.amt_in != '0) begin
            case (bus.mode_in)
                MODE_ROL, MODE_SLL:           w_entry_carry = bus.a_in[w_left_idx];
                MODE_ROR, MODE_SRL, MODE_SRA: w_entry_carry = bus.a_in[w_right_idx];
                default:                      w_entry_carry = 1'b0;
            endcase
        end
    end

    // Carry travels with its data; zero is judged on the value entering the output register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_carry <= '0;
            r_zero  <= 1'b0;
        end else if (!w_stall) begin
            r_carry <= {r_carry[AMT_W-2:0], w_entry_carry};
            r_zero  <= (w_nxt_data[AMT_W-1] == '0);
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - scoreboard bench for pipelined_barrel_shifter
module tb_pipelined_barrel_shifter;
    localparam int W  = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipelined_barrel_shifter_if #(.WIDTH(W)) bus();

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit lat_chk = 1'b0;
    bit rnd_on  = 1'b0;

    logic [W+1:0] exp_q[$];
    int           stamp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference: step-by-one loops, flags as {carry, zero, data}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input int amt, input logic [2:0] mode);
        logic [W-1:0] r;
        logic         c;
        r = a;
        c = 1'b0;
        for (int i = 0; i < amt; i++) begin
            case (mode)
                3'd0:    r = {r[W-2:0], r[W-1]};
                3'd1:    r = {r[0], r[W-1:1]};
                3'd2:    r = {r[W-2:0], 1'b0};
                3'd3:    r = {1'b0, r[W-1:1]};
                3'd4:    r = {r[W-1], r[W-1:1]};
                default: r = r;
            endcase
        end
        if (amt != 0 && mode < 3'd5)
            c = (mode == 3'd0 || mode == 3'd2) ? a[W-amt] : a[amt-1];
        return {c, (r == '0), r};
    endfunction

    task automatic send(input logic [W-1:0] a, input int amt, input logic [2:0] mode, input logic [W-1:0] exp_d);
        logic [W+1:0] m;
        int n;
        @(negedge clk);
        bus.a_in     = a;
        bus.amt_in   = AW'(amt);
        bus.mode_in  = mode;
        bus.valid_in = 1'b1;
        n = 0;
        while (!bus.ready_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept", bus.ready_out, 1);
        if (bus.ready_out) begin
            m = model(a, amt, mode);
            exp_q.push_back({m[W+1:W], exp_d});
            stamp_q.push_back(cyc);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.a_in     = 'x;
        bus.amt_in   = AW'($urandom);
        bus.mode_in  = 3'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_empty", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // Scoreboard: compare every transferred result, and the held result during stalls
    always @(negedge clk) begin
        logic [W+1:0] e;
        logic [W+1:0] got;
        int           s;
        if (!rst) begin
            if (bus.valid_out && !bus.ready_in) begin
                check_eq("stall_ready", bus.ready_out, 0);
                if (exp_q.size() != 0)
                    check_eq("stall_hold", bus.out_out, exp_q[0][W-1:0]);
            end
            if (bus.valid_out && bus.ready_in) begin
                check_eq("queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    s = stamp_q.pop_front();
`ifdef BSH_FLAGS_EN
                    got = {bus.carry_out, bus.zero_out, bus.out_out};
`else
                    got = {2'b00, bus.out_out};
                    e[W+1:W] = 2'b00;
`endif
                    check_eq("result", got, e);
                    if (lat_chk) check_eq("latency", cyc - s, 3);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [2:0]   modes_d[5];
        logic [W-1:0] exp_d[5];
        logic [W-1:0] ra;
        int           rm;
        int           n;

        bus.a_in     = '0;
        bus.amt_in   = '0;
        bus.mode_in  = '0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_valid_out", bus.valid_out, 0);
        check_eq("rst_out_out",   bus.out_out,   0);
        check_eq("rst_ready_out", bus.ready_out, 1);
        rst = 1'b0;

        // Five modes by 2 on 11110000, back to back
        lat_chk = 1'b1;
        modes_d = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        exp_d   = '{8'b11000011, 8'b00111100, 8'b11000000, 8'b00111100, 8'b11111100};
        for (int i = 0; i < 5; i++) send(8'b11110000, 2, modes_d[i], exp_d[i]);
        idle();
        drain();

        // Zero amount and pass-through modes leave the operand untouched
        for (int i = 0; i < 8; i++) send(8'b11110000, 0, 3'(i), 8'b11110000);
        send(8'b11110000, 5, 3'd5, 8'b11110000);
        send(8'b11110000, 3, 3'd7, 8'b11110000);
        idle();
        drain();

        // Largest amount on 10000001
        send(8'b10000001, 7, 3'd0, 8'b11000000);
        send(8'b10000001, 7, 3'd1, 8'b00000011);
        send(8'b10000001, 7, 3'd4, 8'b11111111);
        send(8'b10000001, 7, 3'd3, 8'b00000001);
        idle();
        drain();

        // Backpressure: stall five cycles after the first ROL result
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    ra = W'($urandom);
                    send(ra, i + 1, 3'd0, W'(model(ra, i + 1, 3'd0)));
                end
                idle();
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.valid_out && n < 20);
                check_eq("bp_first_out", bus.valid_out, 1);
                @(posedge clk);
                #1 bus.ready_in = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.ready_in = 1'b1;
            end
        join
        drain();

        // Random traffic with bubbles and random downstream readiness
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) idle();
                    ra = W'($urandom);
                    rm = int'($urandom_range(0, 7));
                    n  = int'($urandom_range(0, W - 1));
                    send(ra, n, 3'(rm), W'(model(ra, n, 3'(rm))));
                end
                idle();
                drain();
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1 bus.ready_in = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.ready_in = 1'b1;
        repeat (4) @(negedge clk);

        // Reset with two transactions in flight: neither may surface
        send(8'hA5, 1, 3'd0, 8'h4B);
        send(8'h3C, 2, 3'd1, 8'h0F);
        @(negedge clk);
        bus.valid_in = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        stamp_q.delete();
        @(negedge clk);
        check_eq("midrst_valid_out", bus.valid_out, 0);
        check_eq("midrst_out_out",   bus.out_out,   0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Flag cases (data checked in every build)
        lat_chk = 1'b1;
        send(8'b11110000, 2, 3'd2, 8'b11000000);
        send(8'b11110000, 4, 3'd3, 8'b00001111);
        send(8'b00000001, 1, 3'd3, 8'b00000000);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined multifunction barrel shifter. Successor to the team's 8-bit combinational rotate-left/right shifter. Supports any power-of-two WIDTH and five operations: rotate left/right, logical shift left/right, arithmetic shift right. Uses one register stage per amount bit and a valid/ready handshake, so it sits directly on a streaming datapath between a producer and a consumer.

Parameters:
WIDTH, 8, data width in bits; power of two, minimum 4
AMT_W, $clog2(WIDTH), shift-amount width and pipeline depth; derived, must not be overridden

Ports:
clk_in  input  1  clock; all logic on rising edge
rst_in  input  1  synchronous active-high reset
a_in  input  WIDTH  operand
amt_in  input  AMT_W  shift/rotate amount, 0..WIDTH-1
mode_in  input  3  operation select (see Behaviour)
valid_in  input  1  operand/amt/mode valid
ready_out  output  1  block can accept input this cycle
out_out  output  WIDTH  result
valid_out  output  1  out_out valid
ready_in  input  1  downstream accepts out_out

Behaviour:
- Reset: when rst_in=1 at a rising edge, all stage valid bits clear. out_out=0, valid_out=0, all stage data=0. Any in-flight transactions are discarded; there is no partial completion.
- mode_in encodings:
  - 000 ROL, 001 ROR
  - 010 SLL (zero fill), 011 SRL (zero fill)
  - 100 SRA (fill with a_in[WIDTH-1])
  - 101..111 pass-through: out_out=a_in, amt ignored
- Pipeline:
  - AMT_W stages. Stage k (k=0..AMT_W-1) shifts/rotates by 2^k when amt bit k is set, otherwise passes data through.
  - Each stage registers data, remaining amount, mode, fill bit and a valid bit.
  - Fill bit for SRA is captured from a_in at entry, not recomputed per stage.
- Latency: exactly AMT_W clock cycles from accepted input to valid_out, with no stalls. Throughput: 1 result/cycle.
- Handshake:
  - stall = valid_out & ~ready_in.
  - ready_out = ~stall (combinational).
  - Input is accepted when valid_in & ready_out.
  - During stall every stage, including the output register, holds its value.
  - Bubbles are not collapsed; a stalled pipeline holds invalid slots in place.
  - valid_out and out_out remain stable while valid_out=1 and ready_in=0.
- Simultaneous accept and output: when valid_out & ready_in, the pipeline advances and a new input is accepted in the same cycle.
- amt_in=0: out_out=a_in for every mode.
- Width rule: amt_in cannot express WIDTH, so the maximum shift is WIDTH-1. Rotates wrap modulo WIDTH.
- valid_in=0: the entry stage loads valid=0. Data content is don't-care but deterministic; it is registered as-is.
- X on a_in while valid_in=0 must not propagate to valid_out.

Optional Feature:
Macro BSH_FLAGS_EN.
- Defined: adds two output ports, both pipelined alongside data and reset to 0.
  - zero_out (1): high when out_out==0.
  - carry_out (1): last bit shifted/rotated out.
    - ROL/SLL: a_in[WIDTH-amt].
    - ROR/SRL/SRA: a_in[amt-1].
    - Forced 0 when amt=0 or mode is pass-through.
  - carry_out is computed at entry from a_in and amt_in.
- Undefined: neither port exists; no flag logic is synthesised; all other behaviour is identical.

Test Plan:
- WIDTH=8, ready_in=1, a_in=8'b11110000, amt=2, modes 000/001/010/011/100 on consecutive cycles:
  - Outputs 11000011 / 00111100 / 11000000 / 00111100 / 11111100.
  - Each appears exactly 3 cycles after acceptance, one per cycle.
- Same operand, amt=0, all modes including 111 -> out_out=11110000 every time.
- Backpressure: stream 4 ROL vectors, drop ready_in for 5 cycles after the first output ->
  - ready_out=0 during the stall; out_out held stable.
  - No loss or duplication; order preserved after release.
- Reset mid-flight: accept 2 vectors, assert rst_in one cycle later ->
  - Next cycle valid_out=0, out_out=0.
  - Neither vector ever appears.
- Wrap/extremes: a_in=8'b10000001, amt=7 -> ROL=11000000, ROR=00000011, SRA=11111111, SRL=00000001.
- With BSH_FLAGS_EN:
  - a_in=8'b11110000 SLL 2 -> carry_out=1, zero_out=0.
  - SRL 4 -> out=00001111, carry_out=0.
  - a_in=8'b00000001 SRL 1 -> out=0, carry_out=1, zero_out=1.
